// File: rtl/addsub_rr_arbiter_if.sv
// Requester-side bundle for the shared 4-bit add/sub unit.
// The ovf signal exists only when ADDSUB_OVF_EN is defined.
interface addsub_rr_arbiter_if;
  logic [1:0] req;
  logic [3:0] a0;
  logic [3:0] b0;
  logic       sub0;
  logic [3:0] a1;
  logic [3:0] b1;
  logic       sub1;
  logic [1:0] ack;
  logic       valid;
  logic [3:0] result;
  logic       cout;
  logic       grant_id;
  logic       busy;
  logic [7:0] op_count;
`ifdef ADDSUB_OVF_EN
  logic       ovf;
`endif

  modport master (
`ifdef ADDSUB_OVF_EN
    input  ovf,
`endif
    output req, a0, b0, sub0,
    output a1, b1, sub1,
    input  ack, valid, result, cout,
    input  grant_id, busy, op_count
  );

  modport slave (
`ifdef ADDSUB_OVF_EN
    output ovf,
`endif
    input  req, a0, b0, sub0,
    input  a1, b1, sub1,
    output ack, valid, result, cout,
    output grant_id, busy, op_count
  );
endinterface

// File: rtl/addsub_rr_arbiter.sv
// Round-robin shared 4-bit adder/subtractor, req/ack per client.
// Define ADDSUB_OVF_EN to add the registered signed-overflow flag.
module addsub_rr_arbiter (
  input  logic                 clk,
  input  logic                 rst,
  addsub_rr_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state, state_n;
  logic       ptr;
  logic       win;
  logic       gid_q;
  logic [3:0] la, lb;
  logic       lsub;
  logic [3:0] bx;
  logic [4:0] sum;
  logic [3:0] res_q;
  logic       cout_q;
  logic [7:0] cnt_q;
`ifdef ADDSUB_OVF_EN
  logic [3:0] low;
  logic       ovf_q;
`endif

  // Both asking: the pointer decides; otherwise the lone requester wins.
  always_comb begin
    win = ptr;
    unique case (bus.req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = ptr;
    endcase
  end

  assign bx  = lb ^ {4{lsub}};
  assign sum = {1'b0, la} + {1'b0, bx}
             + {4'b0, lsub};
`ifdef ADDSUB_OVF_EN
  assign low = {1'b0, la[2:0]} + {1'b0, bx[2:0]}
             + {3'b0, lsub};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    bus.ack   = 2'b00;
    bus.valid = 1'b0;
    bus.busy  = 1'b0;
    unique case (state)
      IDLE: if (|bus.req) state_n = EXEC;
      EXEC: begin
        bus.busy = 1'b1;
        state_n  = RESP;
      end
      RESP: begin
        bus.busy  = 1'b1;
        bus.valid = 1'b1;
        bus.ack   = gid_q ? 2'b10 : 2'b01;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= 1'b0;
      gid_q  <= 1'b0;
      la     <= 4'd0;
      lb     <= 4'd0;
      lsub   <= 1'b0;
      res_q  <= 4'd0;
      cout_q <= 1'b0;
      cnt_q  <= 8'd0;
`ifdef ADDSUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (|bus.req) begin
          gid_q <= win;
          la    <= win ? bus.a1 : bus.a0;
          lb    <= win ? bus.b1 : bus.b0;
          lsub  <= win ? bus.sub1 : bus.sub0;
        end
        EXEC: begin
          res_q  <= sum[3:0];
          cout_q <= sum[4];
`ifdef ADDSUB_OVF_EN
          ovf_q  <= low[3] ^ sum[4];
`endif
        end
        RESP: begin
          cnt_q <= cnt_q + 8'd1;
          ptr   <= ~gid_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.result   = res_q;
  assign bus.cout     = cout_q;
  assign bus.grant_id = gid_q;
  assign bus.op_count = cnt_q;
`ifdef ADDSUB_OVF_EN
  assign bus.ovf      = ovf_q;
`endif

endmodule
